hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised hazard unit for the pipelined RV32 core; successor to the fixed three-stage hazard block. It tracks in-flight destination registers across a configurable number of post-decode stages. From those it generates fetch/decode stalls, bubble insertion, redirect flushes and optional forwarding selects. It also keeps a saturating stall-cycle counter for performance runs in the top-level bench.

## Interface
Parameters:
- NUM_STAGES, 3, post-decode stages tracked (entry 0 = E, entry NUM_STAGES-1 = WB); legal range 2..8
- FWD_EN, 0, 1 = forwarding datapath present (stall only on load-use); 0 = stall on every RAW
- CNT_W, 32, width of the stall counter

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- rs1, rs2, rs3  in  5 each  decode-stage source register indices
- rs_used  in  3  per-operand valid; bit0 = rs1, bit1 = rs2, bit2 = rs3
- reg_RD  in  5  decode-stage destination index
- reg_WE_D  in  1  decode-stage instruction writes reg_RD
- is_load_D  in  1  decode-stage instruction is a load
- redirect_E  in  1  taken branch/jump resolved in E this cycle
- stall_F, stall_D  out  1  hold PC / hold the F→D register
- flush_F, flush_D  out  1  squash fetch / decode contents
- bubble_E  out  1  inject NOP into E next cycle
- fwd_sel1, fwd_sel2, fwd_sel3  out  $clog2(NUM_STAGES)  forward source; 0 = register file, k = entry k-1
- stall_count  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- Scoreboard: NUM_STAGES entries of {valid, rd[4:0], is_load}, shifted one position per clock, entry 0 → 1 → … → NUM_STAGES-1, then discarded.
- Entry 0 load value each cycle:
  - Decode fields {reg_WE_D & (reg_RD != 0), reg_RD, is_load_D} when neither hazard nor redirect_E is active.
  - All zeros (a bubble) otherwise.
- Register file is write-first, so the WB entry (NUM_STAGES-1) never causes a hazard.
- Operand k matches entry j when rs_used[k], entry j valid, rd == rs_k, rs_k != 0, and j <= NUM_STAGES-2.
- Hazard when FWD_EN=0: any operand matches any entry.
- Hazard when FWD_EN=1: any operand matches entry 0 and entry 0 has is_load=1 (load-use).
- fwd_selk:
  - FWD_EN=1: index+1 of the youngest (lowest-j) matching entry, 0 if none.
  - FWD_EN=0: tied to 0.
  - During a load-use hazard, fwd_selk is don't-care.
- Output equations:
  - stall_F = stall_D = hazard & ~redirect_E
  - flush_F = flush_D = redirect_E
  - bubble_E = hazard | redirect_E
- Priority: redirect_E overrides hazard. The stalled decode instruction is on the wrong path and is squashed.
- stall_count increments by 1 each cycle with stall_D=1 and saturates at all-ones. It does not wrap.

## Timing
- All outputs except stall_count are combinational from decode inputs, redirect_E and scoreboard state. They are valid in the same cycle as the decode inputs.
- Scoreboard and stall_count update on the rising clk edge.
- Reset (synchronous, checked at clk edge, including mid-stall):
  - All entries cleared to invalid and stall_count cleared to 0.
  - Consequently, the cycle after reset sees stall_*, bubble_E and fwd_sel* all 0 regardless of decode inputs; flush_* still follow redirect_E.
- RAW stall length with FWD_EN=0 for a producer immediately ahead: NUM_STAGES-1 cycles (2 for the default).
- Producer one slot further ahead: NUM_STAGES-2 stall cycles.
- Load-use stall with FWD_EN=1: exactly 1 cycle. The following cycle shows fwd_sel = 2 (entry 1).
- Simultaneous hazard and redirect_E: no stall, flush asserted, bubble_E=1, stall_count not incremented.
- Multiple operands may match different entries. Each fwd_selk resolves independently.

## Test plan
- NUM_STAGES=3, FWD_EN=0: `addi x5` followed by `add x6,x5,x5` → stall_D=1 for 2 cycles, then 0. bubble_E=1 on both stall cycles. stall_count=2.
- NUM_STAGES=3, FWD_EN=1: same sequence → no stall, fwd_sel1=fwd_sel2=1. With one independent instruction between producer and consumer → fwd_sel1=2.
- FWD_EN=1: `lw x7` then `add x8,x7,x0` → exactly 1 stall cycle, then fwd_sel1=2, fwd_sel2=0.
- Writes to x0, or rs_used=0 on a matching operand → never a stall. NUM_STAGES=5, FWD_EN=0 dependent pair → 4 stall cycles.
- Hazard active with redirect_E=1 in the same cycle → stall_D=0, flush_D=1, bubble_E=1, stall_count unchanged. Reset asserted during the second stall cycle → next cycle all stalls 0 and stall_count=0.
- CNT_W=4 with 20 consecutive forced stall cycles → stall_count holds 15.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the pipelined RV32 core: tracks in-flight destination registers
// across NUM_STAGES post-decode stages and derives stall, flush, bubble and forward selects.
module hazard_scoreboard #(
  parameter int NUM_STAGES = 3,
  parameter bit FWD_EN     = 1'b0,
  parameter int CNT_W      = 32,
  localparam int SEL_W     = $clog2(NUM_STAGES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [4:0]       rs3,
  input  logic [2:0]       rs_used,
  input  logic [4:0]       reg_RD,
  input  logic             reg_WE_D,
  input  logic             is_load_D,
  input  logic             redirect_E,
  output logic             stall_F,
  output logic             stall_D,
  output logic             flush_F,
  output logic             flush_D,
  output logic             bubble_E,
  output logic [SEL_W-1:0] fwd_sel1,
  output logic [SEL_W-1:0] fwd_sel2,
  output logic [SEL_W-1:0] fwd_sel3,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } entry_t;

  entry_t           sb_q [NUM_STAGES];
  entry_t           sb_d [NUM_STAGES];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rs   [3];
  logic [SEL_W-1:0] sel  [3];
  logic             hazard;

  assign rs[0] = rs1;
  assign rs[1] = rs2;
  assign rs[2] = rs3;

  // The WB entry is excluded from matching: the register file is write-first.
  // Scanning from oldest to youngest lets the youngest match win the select.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    hazard = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sel[k] = '0;
      for (int j = NUM_STAGES - 2; j >= 0; j--) begin
        if (rs_used[k] && sb_q[j].valid && (sb_q[j].rd == rs[k]) && (rs[k] != 5'd0)) begin
          sel[k] = SEL_W'(j + 1);
          if (!FWD_EN || ((j == 0) && sb_q[0].is_load)) begin
            hazard = 1'b1;
          end
        end
      end
    end
  end

  // A redirect squashes the stalled decode instruction, so it wins over the hazard.
  assign stall_F  = hazard & ~redirect_E;
  assign stall_D  = hazard & ~redirect_E;
  assign flush_F  = redirect_E;
  assign flush_D  = redirect_E;
  assign bubble_E = hazard | redirect_E;

  assign fwd_sel1 = FWD_EN ? sel[0] : '0;
  assign fwd_sel2 = FWD_EN ? sel[1] : '0;
  assign fwd_sel3 = FWD_EN ? sel[2] : '0;

  assign stall_count = cnt_q;

  always_comb begin
    if (hazard || redirect_E) begin
      sb_d[0] = '0;
    end else begin
      sb_d[0] = '{valid: reg_WE_D && (reg_RD != 5'd0), rd: reg_RD, is_load: is_load_D};
    end
    for (int j = 1; j < NUM_STAGES; j++) begin
      sb_d[j] = sb_q[j-1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_D && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      for (int j = 0; j < NUM_STAGES; j++) begin
        sb_q[j] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int j = 0; j < NUM_STAGES; j++) begin
        sb_q[j] <= sb_d[j];
      end
      cnt_q <= cnt_d;
    end
  end

endmodule
